// File: rtl/avmm_csr_slave.sv
// Avalon-MM CSR slave: 8-word register bank with 2-cycle pipelined reads,
// sticky event capture, saturating event counter and 64-bit timestamp.
module avmm_csr_slave #(
   parameter logic [31:0] ID_VALUE  = 32'h05D1_0001,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_clk,
   input  logic        clk_reset_reset_n,
   input  logic [31:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic [31:0] ctrl_out,
   input  logic [31:0] status_in,
   input  logic [7:0]  event_in
);

   localparam int unsigned DW  = 32;
   localparam int unsigned EW  = 8;
   localparam int unsigned TSW = 64;
   localparam int unsigned BW  = 4;

   localparam logic [2:0] A_ID      = 3'd0;
   localparam logic [2:0] A_SCRATCH = 3'd1;
   localparam logic [2:0] A_CONTROL = 3'd2;
   localparam logic [2:0] A_STATUS  = 3'd3;
   localparam logic [2:0] A_STICKY  = 3'd4;
   localparam logic [2:0] A_EVT_CNT = 3'd5;
   localparam logic [2:0] A_TS_LO   = 3'd6;
   localparam logic [2:0] A_TS_HI   = 3'd7;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t state_q, state_d;
   logic   waitrequest_c;

   logic [DW-1:0]  scratch, control, evt_cnt, evt_cnt_d, ts_hi_latch;
   logic [EW-1:0]  sticky, sticky_d, event_q, rise, w1c_mask;
   logic [TSW-1:0] ts;
   logic [DW-1:0]  rd_data, s1_data;
   logic           s1_valid;
   logic           in_window, wr_en, rd_en;
   logic [2:0]     word;
   logic           unused_addr;

   // Bus stalls only for the single cycle following reset release
   always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
      if (!clk_reset_reset_n) state_q <= ST_INIT;
      else                    state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   always_comb begin
      waitrequest_c = 1'b1;
      if (state_q == ST_RUN) waitrequest_c = 1'b0;
   end

   assign avs_waitrequest = waitrequest_c;

   assign unused_addr = ^avs_address[1:0];
   assign word        = avs_address[4:2];
   assign in_window   = (avs_address[31:5] == BASE_ADDR[31:5]);
   assign wr_en       = avs_write & ~waitrequest_c & in_window;
   assign rd_en       = avs_read & ~avs_write & ~waitrequest_c;
   assign rise        = event_in & ~event_q;

   function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [BW-1:0] be);
      logic [DW-1:0] res;
      res = old_v;
      for (int i = 0; i < int'(BW); i++)
         if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      return res;
   endfunction

   // Read mux; out-of-window reads return zero
   always_comb begin
      rd_data = '0;
      if (in_window) begin
         case (word)
            A_ID:      rd_data = ID_VALUE;
            A_SCRATCH: rd_data = scratch;
            A_CONTROL: rd_data = control;
            A_STATUS:  rd_data = status_in;
            A_STICKY:  rd_data = DW'(sticky);
            A_EVT_CNT: rd_data = evt_cnt;
            A_TS_LO:   rd_data = ts[DW-1:0];
            A_TS_HI:   rd_data = ts_hi_latch;
            default:   rd_data = '0;
         endcase
      end
   end

   // Rising edges set sticky bits even when a W1C hits the same bit
   always_comb begin
      w1c_mask = '0;
      if (wr_en && word == A_STICKY && avs_byteenable[0])
         w1c_mask = avs_writedata[EW-1:0];
      sticky_d = (sticky & ~w1c_mask) | rise;
   end

   always_comb begin
      evt_cnt_d = evt_cnt;
      if (wr_en && word == A_EVT_CNT)
         evt_cnt_d = rise[0] ? DW'(1) : '0;
      else if (rise[0] && evt_cnt != '1)
         evt_cnt_d = evt_cnt + DW'(1);
   end

   always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
      if (!clk_reset_reset_n) begin
         scratch     <= '0;
         control     <= '0;
         sticky      <= '0;
         evt_cnt     <= '0;
         ts          <= '0;
         ts_hi_latch <= '0;
         event_q     <= '0;
      end else begin
         event_q <= event_in;
         sticky  <= sticky_d;
         evt_cnt <= evt_cnt_d;
         ts      <= ts + TSW'(1);
         if (wr_en && word == A_SCRATCH)
            scratch <= be_merge(scratch, avs_writedata, avs_byteenable);
         if (wr_en && word == A_CONTROL)
            control <= be_merge(control, avs_writedata, avs_byteenable);
         if (rd_en && in_window && word == A_TS_LO)
            ts_hi_latch <= ts[TSW-1:DW];
      end
   end

   assign ctrl_out = control;

   // Two-stage read pipeline; readdata holds between strobes
   always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
      if (!clk_reset_reset_n) begin
         s1_valid          <= 1'b0;
         s1_data           <= '0;
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
      end else begin
         s1_valid          <= rd_en;
         if (rd_en) s1_data <= rd_data;
         avs_readdatavalid <= s1_valid;
         if (s1_valid) avs_readdata <= s1_data;
      end
   end

endmodule

// File: tb/tb_avmm_csr_slave.sv
// Self-checking bench for avmm_csr_slave: vector table plus scoreboard of
// expected read data, with hand sequences for events, timestamp and reset.
module tb_avmm_csr_slave;

   localparam logic [31:0] ID = 32'h05D1_0001;

   logic        clk, rst_n;
   logic [31:0] avs_address, avs_writedata, avs_readdata, ctrl_out, status_in;
   logic        avs_read, avs_write, avs_readdatavalid, avs_waitrequest;
   logic [3:0]  avs_byteenable;
   logic [7:0]  event_in;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   logic bypass = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] cap_q[$];
   int          cap_cyc[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] status;
      logic [31:0] exp_rd;
      logic [31:0] exp_ctrl;
   } vec_t;
   vec_t vecs[$];

   avmm_csr_slave dut (
      .clk_clk           (clk),
      .clk_reset_reset_n (rst_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avs_waitrequest   (avs_waitrequest),
      .ctrl_out          (ctrl_out),
      .status_in         (status_in),
      .event_in          (event_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every readdatavalid pops the oldest expected read
   always @(negedge clk) begin
      if (rst_n && avs_readdatavalid) begin
         if (bypass) begin
            cap_q.push_back(avs_readdata);
            cap_cyc.push_back(cyc_cnt);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_rdv", 64'(avs_readdatavalid), 64'd0);
         end else begin
            chk("sb_read", 64'(avs_readdata), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic idle();
      avs_read = 1'b0; avs_write = 1'b0;
      avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
   endtask

   task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp);
      avs_read = rd; avs_write = wr; avs_address = addr;
      avs_writedata = wdata; avs_byteenable = be;
      if (rd && !wr && !bypass) exp_q.push_back(exp);
      @(negedge clk);
      idle();
   endtask

   task automatic pulse(input logic [7:0] ev);
      event_in = ev;
      @(negedge clk);
      event_in = '0;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      #1 chk("wait_after_release", 64'(avs_waitrequest), 64'd1);
      @(negedge clk);
      chk("wait_one_cycle", 64'(avs_waitrequest), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; status_in = '0; event_in = '0;
      idle();
      repeat (3) @(negedge clk);
      chk("rst_readdata", 64'(avs_readdata), 64'd0);
      chk("rst_rdv", 64'(avs_readdatavalid), 64'd0);
      chk("rst_wait", 64'(avs_waitrequest), 64'd1);
      chk("rst_ctrl", 64'(ctrl_out), 64'd0);

      // First read right after the stall cycle: latency and hold
      release_reset();
      bus_op(1, 0, 32'h00, 0, 0, ID);
      chk("lat_early", 64'(avs_readdatavalid), 64'd0);
      @(negedge clk);
      chk("lat_valid", 64'(avs_readdatavalid), 64'd1);
      @(negedge clk);
      chk("rdv_single", 64'(avs_readdatavalid), 64'd0);
      chk("readdata_hold", 64'(avs_readdata), 64'(ID));

      vecs.push_back('{0, 1, 32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0});
      vecs.push_back('{0, 1, 32'h04, 32'h11223344, 4'h5, 0, 0, 0});
      vecs.push_back('{1, 0, 32'h04, 0, 0, 0, 32'hAA22CC44, 0});
      vecs.push_back('{0, 1, 32'h08, 32'h000000F0, 4'hF, 0, 0, 32'hF0});
      vecs.push_back('{1, 0, 32'h08, 0, 0, 0, 32'hF0, 32'hF0});
      vecs.push_back('{0, 1, 32'h08, 32'h12345678, 4'h8, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h00, 0, 0, 0, ID, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h20, 0, 0, 0, 0, 32'h120000F0});
      vecs.push_back('{0, 1, 32'h28, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h0C, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h120000F0});
      vecs.push_back('{0, 1, 32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h00, 0, 0, 0, ID, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h10, 0, 0, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 1, 32'h04, 32'h5555AAAA, 4'hF, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h04, 0, 0, 0, 32'h5555AAAA, 32'h120000F0});
      vecs.push_back('{0, 1, 32'h04, 32'h0, 4'hF, 0, 0, 32'h120000F0});
      vecs.push_back('{1, 0, 32'h04, 0, 0, 0, 32'h0, 32'h120000F0});
      foreach (vecs[i]) begin
         status_in = vecs[i].status;
         bus_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_rd);
         chk($sformatf("vec%0d_ctrl", i), 64'(ctrl_out), 64'(vecs[i].exp_ctrl));
      end
      drain();

      // Sticky capture, W1C, and set-wins collision
      pulse(8'h81);
      bus_op(1, 0, 32'h10, 0, 0, 32'h81);
      bus_op(0, 1, 32'h10, 32'h01, 4'h1, 0);
      bus_op(1, 0, 32'h10, 0, 0, 32'h80);
      event_in = 8'h80;
      bus_op(0, 1, 32'h10, 32'h80, 4'h1, 0);
      event_in = '0;
      @(negedge clk);
      bus_op(1, 0, 32'h10, 0, 0, 32'h80);
      bus_op(0, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 0);
      bus_op(1, 0, 32'h10, 0, 0, 32'h0);

      // Event counter: count, clear/rise collision, saturation
      bus_op(0, 1, 32'h14, 32'h0, 4'hF, 0);
      for (int i = 0; i < 5; i++) pulse(8'h01);
      bus_op(1, 0, 32'h14, 0, 0, 32'd5);
      event_in = 8'h01;
      bus_op(0, 1, 32'h14, 32'h0, 4'hF, 0);
      event_in = '0;
      @(negedge clk);
      bus_op(1, 0, 32'h14, 0, 0, 32'd1);
      force dut.evt_cnt = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.evt_cnt;
      for (int i = 0; i < 3; i++) pulse(8'h01);
      bus_op(1, 0, 32'h14, 0, 0, 32'hFFFF_FFFF);
      drain();

      // Timestamp: back-to-back reads of words 6,7,6
      bypass = 1'b1;
      cap_q.delete(); cap_cyc.delete();
      force dut.ts = 64'h0000_0005_FFFF_FFF0;
      @(negedge clk);
      release dut.ts;
      bus_op(1, 0, 32'h18, 0, 0, 0);
      bus_op(1, 0, 32'h1C, 0, 0, 0);
      bus_op(1, 0, 32'h18, 0, 0, 0);
      for (int i = 0; i < 10 && cap_q.size() < 3; i++) @(negedge clk);
      chk("ts_count", 64'(cap_q.size()), 64'd3);
      if (cap_q.size() == 3) begin
         chk("ts_hi_latch", 64'(cap_q[1]), 64'd5);
         chk("ts_lo_delta", 64'(cap_q[2] - cap_q[0]), 64'd2);
         chk("ts_consec1", 64'(cap_cyc[1] - cap_cyc[0]), 64'd1);
         chk("ts_consec2", 64'(cap_cyc[2] - cap_cyc[1]), 64'd1);
      end

      // Reset between accept and readdatavalid
      cap_q.delete(); cap_cyc.delete();
      avs_read = 1'b1; avs_address = 32'h00;
      @(posedge clk);
      #2 rst_n = 1'b0;
      idle();
      #1;
      chk("mid_rst_rdv", 64'(avs_readdatavalid), 64'd0);
      chk("mid_rst_readdata", 64'(avs_readdata), 64'd0);
      chk("mid_rst_wait", 64'(avs_waitrequest), 64'd1);
      chk("mid_rst_ctrl", 64'(ctrl_out), 64'd0);
      repeat (3) @(negedge clk);
      chk("mid_rst_no_rdv", 64'(cap_q.size()), 64'd0);
      bypass = 1'b0;
      release_reset();
      bus_op(1, 0, 32'h04, 0, 0, 32'h0);
      bus_op(1, 0, 32'h10, 0, 0, 32'h0);
      bus_op(1, 0, 32'h00, 0, 0, ID);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
